dq4_wr_ctrl: RTL



---
 rtl/dq4_wr_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dq4_wr_ctrl.sv
// rtl/dq4_wr_ctrl.sv - write sequencer for a 4-word x 4-bit DQ4 latch array
//
// Accepts one write at a time over req_i/ready_o, then drives the latch
// array through three timed phases: data setup (all enables low), a single
// one-hot enable pulse, and data hold (all enables low). A shared 4-bit
// down-counter sets the dwell in each phase.
//
// Ports:
//   clk_i    - sole clock, rising edge
//   rst_i    - synchronous active-high reset
//   req_i    - write request valid
//   addr_i   - target word 0..3
//   data_i   - write data, bit 0 is the MSB (DQ4 D bus order)
//   ready_o  - request can be accepted this cycle
//   d_o      - registered data bus to all four words
//   en_o     - registered per-word latch enable, en_o[i] drives word i
//   done_o   - one-cycle pulse in the IDLE cycle that ends a write

module dq4_wr_ctrl #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 1,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  logic [1:0] addr_i,
  input  logic [0:3] data_i,
  output logic       ready_o,
  output logic [0:3] d_o,
  output logic [0:3] en_o,
  output logic       done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Counter reload values: a phase of N cycles loads N-1 on entry and
  // leaves when the counter reads zero.
  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q,   cnt_d;
  logic [1:0] addr_q,  addr_d;
  logic [0:3] d_q,     d_d;
  logic [0:3] en_q,    en_d;
  logic       done_q,  done_d;
  logic       accept;

  // ready is the only combinational output; it is masked during reset so
  // nothing can be accepted on the reset edge.
  assign ready_o = (state_q == IDLE) && !rst_i;
  assign accept  = req_i && ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != 4'd0) ? (cnt_q - 4'd1) : cnt_q;
    addr_d  = addr_q;
    d_d     = d_q;
    en_d    = 4'b0000;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          addr_d  = addr_i;
          // d_q doubles as the captured data register: it is written only
          // here and therefore stays frozen for the whole transaction.
          d_d     = data_i;
          cnt_d   = SETUP_LD;
        end
      end

      SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d      = PULSE;
          en_d[addr_q] = 1'b1;
          cnt_d        = PULSE_LD;
        end
      end

      PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          // Keep the enable asserted through the remaining pulse cycles;
          // en_d defaults low so the pulse ends cleanly on the HOLD edge.
          en_d[addr_q] = 1'b1;
        end
      end

      HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 2'd0;
      d_q     <= 4'b0000;
      en_q    <= 4'b0000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      d_q     <= d_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign d_o    = d_q;
  assign en_o   = en_q;
  assign done_o = done_q;

endmodule
